// File: rtl/dac80004_pkg.sv
// Shared types and frame assembly for the DAC80004 command sequencer.
package dac80004_pkg;

    typedef enum logic [3:0] {
        CMD_WRITE_BUF        = 4'h0,
        CMD_WRITE_UPDATE_ALL = 4'h2
    } dac_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_GAP
    } seq_state_e;

    localparam int CODE_W  = 16;
    localparam int FRAME_W = 32;

    // 32-bit DAC80004 word: 4 don't-care MSBs, command, address, code, 4 don't-care LSBs.
    function automatic logic [FRAME_W-1:0] dac_frame(input dac_cmd_e cmd,
                                                     input logic [3:0] addr,
                                                     input logic [CODE_W-1:0] code);
        return {4'h0, cmd, addr, code, 4'h0};
    endfunction

endpackage

// File: rtl/dac80004_sequencer_if.sv
// Frame handshake between the sequencer and the SPI master.
interface dac80004_sequencer_if;
    import dac80004_pkg::*;

    logic               spi_tx_valid;
    logic [FRAME_W-1:0] spi_tx_data;
    logic               spi_tx_ready;

    modport master (
        output spi_tx_valid,
        output spi_tx_data,
        input  spi_tx_ready
    );

    modport slave (
        input  spi_tx_valid,
        input  spi_tx_data,
        output spi_tx_ready
    );

endinterface

// File: rtl/dac80004_sequencer.sv
// Snapshots channel codes on commit and streams one DAC80004 frame per enabled
// channel, the highest enabled one carrying the update-all command.
module dac80004_sequencer
    import dac80004_pkg::*;
#(
    parameter int NCH            = 4,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CODE_W*NCH-1:0] ch_data,
    input  logic [NCH-1:0]        ch_mask,
    input  logic                  commit,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           frame_count,
    dac80004_sequencer_if.master  spi
);

    localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NCH-1:0]          act_mask_q, act_mask_d;
    logic [CODE_W*NCH-1:0]   act_data_q, act_data_d;
    logic                    pend_q, pend_d;
    logic [NCH-1:0]          pend_mask_q, pend_mask_d;
    logic [CODE_W*NCH-1:0]   pend_data_q, pend_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [15:0]             fcnt_q, fcnt_d;
    logic                    valid_q, valid_d;
    logic [FRAME_W-1:0]      txdata_q, txdata_d;

    logic                    sel_found;
    int                      sel_n;
    logic [NCH-1:0]          rem_mask;
    dac_cmd_e                sel_cmd;
    logic                    start_seq;
    logic [NCH-1:0]          start_mask;
    logic [CODE_W*NCH-1:0]   start_data;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        act_mask_d  = act_mask_q;
        act_data_d  = act_data_q;
        pend_d      = pend_q;
        pend_mask_d = pend_mask_q;
        pend_data_d = pend_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        fcnt_d      = fcnt_q;
        valid_d     = valid_q;
        txdata_d    = txdata_q;
        start_seq   = 1'b0;

        // Lowest remaining channel is the next one on the wire.
        sel_found = 1'b0;
        sel_n     = 0;
        for (int n = NCH - 1; n >= 0; n--) begin
            if (act_mask_q[n]) begin
                sel_found = 1'b1;
                sel_n     = n;
            end
        end
        rem_mask = act_mask_q & ~(NCH'(1) << sel_n);
        sel_cmd  = CMD_WRITE_BUF;
        if (rem_mask == '0) begin
            sel_cmd = CMD_WRITE_UPDATE_ALL;
        end

        if (commit && (state_q != ST_IDLE)) begin
            pend_d      = 1'b1;
            pend_mask_d = ch_mask;
            pend_data_d = ch_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    start_seq = 1'b1;
                end
            end
            ST_LOAD: begin
                if (sel_found) begin
                    txdata_d   = dac_frame(sel_cmd, 4'(sel_n), act_data_q[CODE_W*sel_n +: CODE_W]);
                    valid_d    = 1'b1;
                    act_mask_d = rem_mask;
                    cnt_d      = '0;
                    state_d    = ST_WAIT;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                    if (commit || pend_q) begin
                        start_seq = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (spi.spi_tx_ready) begin
                    valid_d = 1'b0;
                    fcnt_d  = fcnt_q + 16'd1;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else if (cnt_q == TO_LAST) begin
                    // Abandon the rest of this sequence and any queued one.
                    valid_d    = 1'b0;
                    error_d    = 1'b1;
                    pend_d     = 1'b0;
                    act_mask_d = '0;
                    cnt_d      = '0;
                    state_d    = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A same-cycle commit is newer than anything already pending.
        start_mask = commit ? ch_mask : pend_mask_q;
        start_data = commit ? ch_data : pend_data_q;
        if (start_seq) begin
            pend_d     = 1'b0;
            error_d    = 1'b0;
            act_mask_d = start_mask;
            act_data_d = start_data;
            if (start_mask == '0) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end else begin
                busy_d  = 1'b1;
                state_d = ST_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            act_mask_q <= '0;
            pend_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            fcnt_q     <= '0;
            valid_q    <= 1'b0;
            txdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_mask_q <= act_mask_d;
            pend_q     <= pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            fcnt_q     <= fcnt_d;
            valid_q    <= valid_d;
            txdata_q   <= txdata_d;
        end
    end

    // Snapshot payloads carry no control meaning, so they skip reset.
    always_ff @(posedge clk) begin
        act_data_q  <= act_data_d;
        pend_mask_q <= pend_mask_d;
        pend_data_q <= pend_data_d;
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign frame_count      = fcnt_q;
    assign spi.spi_tx_valid = valid_q;
    assign spi.spi_tx_data  = txdata_q;

endmodule

// File: tb/tb_dac80004_sequencer.sv
// Directed bench for dac80004_sequencer with a frame/count reference model.
module tb_dac80004_sequencer;

    localparam int GAP  = 8;
    localparam int TOUT = 4096;

    logic        clk;
    logic        reset;
    logic [63:0] ch_data;
    logic [3:0]  ch_mask;
    logic        commit;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] frame_count;

    dac80004_sequencer_if spi_if();

    dac80004_sequencer #(
        .NCH(4), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk(clk), .reset(reset), .ch_data(ch_data), .ch_mask(ch_mask),
        .commit(commit), .busy(busy), .done(done), .error(error),
        .frame_count(frame_count), .spi(spi_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          done_seen = 0;
    logic [15:0] exp_fc = 16'd0;
    logic [31:0] exp_q[$];

    // Acknowledged frames: a ready pulse while a frame is being offered.
    always @(posedge clk) begin
        if (reset) exp_fc <= 16'd0;
        else if (spi_if.spi_tx_ready && spi_if.spi_tx_valid) exp_fc <= exp_fc + 16'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic void push_frames(input logic [63:0] d, input logic [3:0] m);
        int last;
        last = -1;
        for (int n = 0; n < 4; n++) if (m[n]) last = n;
        for (int n = 0; n < 4; n++) begin
            if (m[n]) begin
                exp_q.push_back(((n == last ? 32'h2 : 32'h0) << 24) | (32'(n) << 20)
                                | (32'(d[16*n +: 16]) << 4));
            end
        end
    endfunction

    task automatic do_commit(input logic [63:0] d, input logic [3:0] m);
        ch_data = d;
        ch_mask = m;
        commit  = 1'b1;
        push_frames(d, m);
        tick();
        commit  = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (spi_if.spi_tx_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_valid: spi_tx_valid stayed 0 for 200 cycles, required 1");
        end
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_done: done stayed 0 for %0d cycles, required 1", bound);
        end
    endtask

    task automatic serve_frame(input logic [31:0] req, input int lat);
        bit ok;
        wait_valid(ok);
        if (ok) check("frame_word", spi_if.spi_tx_data, req);
        repeat (lat) tick();
        spi_if.spi_tx_ready = 1'b1;
        tick();
        spi_if.spi_tx_ready = 1'b0;
    endtask

    // Per-cycle compare against the reference model.
    task automatic monitor();
        logic        prev_valid;
        logic [31:0] prev_data;
        int          low_run;
        prev_valid = 1'b0;
        prev_data  = '0;
        low_run    = 1000;
        forever begin
            @(negedge clk);
            check("frame_count_model", 32'(frame_count), 32'(exp_fc));
            if (spi_if.spi_tx_valid) check("valid_implies_busy", 32'(busy), 32'd1);
            if (done) done_seen++;
            if (spi_if.spi_tx_valid && !prev_valid) begin
                checks++;
                if (low_run < GAP + 1) begin
                    errors++;
                    $display("FAIL gap_low: valid low %0d cycles, required >= %0d", low_run, GAP + 1);
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got 0x%08h, required no frame", spi_if.spi_tx_data);
                end else begin
                    check("frame_model", spi_if.spi_tx_data, exp_q.pop_front());
                end
            end else if (spi_if.spi_tx_valid && prev_valid) begin
                check("data_stable", spi_if.spi_tx_data, prev_data);
            end
            low_run    = spi_if.spi_tx_valid ? 0 : ((low_run < 1000) ? low_run + 1 : low_run);
            prev_valid = spi_if.spi_tx_valid;
            prev_data  = spi_if.spi_tx_data;
        end
    endtask

    initial begin
        int n;
        int d0;
        int hi;
        bit ok;
        reset = 1'b1;
        commit = 1'b0;
        ch_data = '0;
        ch_mask = '0;
        spi_if.spi_tx_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_valid", 32'(spi_if.spi_tx_valid), 32'd0);
        check("rst_data", spi_if.spi_tx_data, 32'd0);
        reset = 1'b0;
        fork
            monitor();
        join_none
        tick();

        // Single channel
        d0 = done_seen;
        do_commit(64'h0000_0000_0000_8000, 4'b0001);
        check("t1_busy_after_commit", 32'(busy), 32'd1);
        check("t1_valid_after_commit", 32'(spi_if.spi_tx_valid), 32'd0);
        tick();
        check("t1_valid_rise", 32'(spi_if.spi_tx_valid), 32'd1);
        check("t1_frame", spi_if.spi_tx_data, 32'h0208_0000);
        repeat (40) tick();
        spi_if.spi_tx_ready = 1'b1;
        tick();
        spi_if.spi_tx_ready = 1'b0;
        check("t1_valid_drop", 32'(spi_if.spi_tx_valid), 32'd0);
        wait_done(100, n);
        check("t1_done_latency", 32'(n), 32'(GAP + 1));
        check("t1_busy_at_done", 32'(busy), 32'd0);
        check("t1_frame_count", 32'(frame_count), 32'd1);
        tick();
        check("t1_done_one_cycle", 32'(done), 32'd0);
        tick();
        check("t1_done_pulses", 32'(done_seen - d0), 32'd1);

        // Two channels
        d0 = done_seen;
        do_commit(64'hABCD_0000_1234_0000, 4'b1010);
        serve_frame(32'h0011_2340, 5);
        serve_frame(32'h023A_BCD0, 2);
        wait_done(100, n);
        repeat (3) tick();
        check("t2_done_pulses", 32'(done_seen - d0), 32'd1);
        check("t2_frame_count", 32'(frame_count), 32'd3);

        // Empty mask
        do_commit(64'h1111_2222_3333_4444, 4'b0000);
        check("t3_done_next_cycle", 32'(done), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_busy_stays_low", 32'(busy), 32'd0);
            check("t3_valid_stays_low", 32'(spi_if.spi_tx_valid), 32'd0);
        end

        // Timeout
        do_commit(64'h0000_0000_0000_0001, 4'b0001);
        tick();
        hi = 0;
        while (spi_if.spi_tx_valid && hi < TOUT + 100) begin
            hi++;
            tick();
        end
        check("t4_valid_high_cycles", 32'(hi), 32'(TOUT));
        check("t4_error_set", 32'(error), 32'd1);
        wait_done(100, n);
        check("t4_error_at_done", 32'(error), 32'd1);
        check("t4_frame_count", 32'(frame_count), 32'd3);
        tick();
        do_commit(64'h0000_0000_0000_7FFF, 4'b0001);
        check("t4_error_cleared", 32'(error), 32'd0);
        serve_frame(32'h0207_FFF0, 3);
        wait_done(100, n);
        tick();
        check("t4_frame_count_after", 32'(frame_count), 32'd4);

        // Pending commit during frame 1
        do_commit(64'h4444_3333_2222_1111, 4'b1111);
        wait_valid(ok);
        check("t5_frame0", spi_if.spi_tx_data, 32'h0001_1110);
        tick();
        do_commit(64'h0000_0FFF_0000_0000, 4'b0100);
        tick();
        spi_if.spi_tx_ready = 1'b1;
        tick();
        spi_if.spi_tx_ready = 1'b0;
        serve_frame(32'h0012_2220, 1);
        serve_frame(32'h0023_3330, 1);
        serve_frame(32'h0234_4440, 1);
        wait_done(100, n);
        tick();
        check("t5_pending_valid", 32'(spi_if.spi_tx_valid), 32'd1);
        check("t5_pending_frame", spi_if.spi_tx_data, 32'h0220_FFF0);
        spi_if.spi_tx_ready = 1'b1;
        tick();
        spi_if.spi_tx_ready = 1'b0;
        wait_done(100, n);
        tick();
        check("t5_frame_count", 32'(frame_count), 32'd9);
        check("t5_busy_end", 32'(busy), 32'd0);

        // Reset during WAIT
        do_commit(64'h0000_0000_0000_0042, 4'b0001);
        wait_valid(ok);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_valid_after_reset", 32'(spi_if.spi_tx_valid), 32'd0);
        check("t6_busy_after_reset", 32'(busy), 32'd0);
        check("t6_data_after_reset", spi_if.spi_tx_data, 32'd0);
        check("t6_fc_after_reset", 32'(frame_count), 32'd0);
        tick();
        spi_if.spi_tx_ready = 1'b1;
        tick();
        spi_if.spi_tx_ready = 1'b0;
        repeat (3) tick();
        check("t6_stray_ready_fc", 32'(frame_count), 32'd0);
        check("t6_stray_ready_valid", 32'(spi_if.spi_tx_valid), 32'd0);
        check("t6_stray_ready_busy", 32'(busy), 32'd0);
        check("all_frames_seen", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
